bullet_hit_detector: RTL and testbench

- Downstream of the per-bullet sprite generators; consumes their registered BulletSpriteOn bits and the heart sprite bit on the same pixel stream.
- Detects per-frame pixel overlap and commits hits once per frame at the last pixel.
- Maintains player HP, invulnerability window and game-over state.
- Drives the isCollision bits back to each bullet generator so hit bullets are hidden.

---
 rtl/bullet_hit_detector.sv | 167 ++++++++++++++++
 tb/tb_bullet_hit_detector.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_hit_detector.sv
// bullet_hit_detector
//   Watches the pixel stream for overlap between the heart sprite and each
//   bullet sprite. Overlaps are accumulated across a frame, and any hits are
//   committed once at the last active pixel. The block tracks player HP, a
//   post-hit invulnerability window and a terminal game-over state. It also
//   tells each bullet generator to hide a bullet that has hit.
//
// Ports
//   Pclk           pixel clock
//   reset          asynchronous, active-high
//   xx, yy         current pixel coordinates
//   aactive        active-video qualifier
//   BulletSpriteOn per-bullet pixel bits (registered, 1-cycle latency)
//   HeartSpriteOn  heart pixel bit (same latency as BulletSpriteOn)
//   isCollision    per-bullet hide request
//   hp             current HP
//   hit_pulse      one-cycle strobe after a committed hit
//   invuln         high while invulnerable
//   heart_visible  heart draw enable
//   game_over      high once HP reaches zero
//
// Build option
//   HIT_FLASH_EN   when defined, the heart blinks every 4 frames while
//                  invulnerable; otherwise heart_visible is tied high.

module bullet_hit_detector #(
  parameter int NUM_BULLETS   = 2,
  parameter int HP_INIT       = 20,
  parameter int DAMAGE        = 1,
  parameter int INVULN_FRAMES = 30,
  parameter int H_LAST        = 639,
  parameter int V_LAST        = 479
) (
  input  logic                   Pclk,
  input  logic                   reset,
  input  logic [9:0]             xx,
  input  logic [9:0]             yy,
  input  logic                   aactive,
  input  logic [NUM_BULLETS-1:0] BulletSpriteOn,
  input  logic                   HeartSpriteOn,
  output logic [NUM_BULLETS-1:0] isCollision,
  output logic [7:0]             hp,
  output logic                   hit_pulse,
  output logic                   invuln,
  output logic                   heart_visible,
  output logic                   game_over
);

  localparam int FCW = $clog2(INVULN_FRAMES) + 1;
  localparam logic [FCW-1:0] FC_LAST = FCW'(INVULN_FRAMES - 1);
  localparam logic [7:0]     HP_RST  = 8'(HP_INIT);
  localparam logic [7:0]     DMG     = 8'(DAMAGE);

  typedef enum logic [1:0] {
    ALIVE,
    INVULN,
    DEAD
  } state_t;

  state_t                 state;
  logic [NUM_BULLETS-1:0] pending;
  logic [FCW-1:0]         frame_cnt;

  logic                   fe;
  logic [NUM_BULLETS-1:0] ov;
  logic [NUM_BULLETS-1:0] hit_vec;
  logic [7:0]             hp_dec;
  logic                   inv_last;

  always_comb begin
    fe       = (xx == 10'(H_LAST)) && (yy == 10'(V_LAST));
    ov       = (aactive && HeartSpriteOn) ? BulletSpriteOn : '0;
    // The overlap on the frame-end pixel itself belongs to the frame being closed.
    hit_vec  = pending | ov;
    hp_dec   = (hp > DMG) ? (hp - DMG) : '0;
    inv_last = (frame_cnt == FC_LAST);
  end

  always_ff @(posedge Pclk or posedge reset) begin
    if (reset) begin
      state       <= ALIVE;
      hp          <= HP_RST;
      pending     <= '0;
      isCollision <= '0;
      frame_cnt   <= '0;
      hit_pulse   <= 1'b0;
      invuln      <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      hit_pulse <= 1'b0;
      case (state)
        ALIVE: begin
          if (fe) begin
            pending <= '0;
            if (|hit_vec) begin
              hit_pulse <= 1'b1;
              hp        <= hp_dec;
              if (hp_dec == '0) begin
                state       <= DEAD;
                isCollision <= '1;
                game_over   <= 1'b1;
              end else begin
                state       <= INVULN;
                invuln      <= 1'b1;
                isCollision <= hit_vec;
                frame_cnt   <= '0;
              end
            end
          end else begin
            pending <= hit_vec;
          end
        end

        INVULN: begin
          pending <= '0;
          if (fe) begin
            if (inv_last) begin
              state       <= ALIVE;
              invuln      <= 1'b0;
              isCollision <= '0;
              frame_cnt   <= '0;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end

        DEAD: begin
          pending     <= '0;
          isCollision <= '1;
          hp          <= '0;
          invuln      <= 1'b0;
          game_over   <= 1'b1;
        end

        default: begin
          state <= ALIVE;
        end
      endcase
    end
  end

`ifdef HIT_FLASH_EN
  logic [FCW-1:0] fc_inc;
  logic           inv_step;

  always_comb begin
    fc_inc   = frame_cnt + 1'b1;
    inv_step = (state == INVULN) && fe && !inv_last;
  end

  // Follows the frame counter's next value so the blink lines up with the
  // registered invuln/frame_cnt outputs rather than lagging them by a cycle.
  always_ff @(posedge Pclk or posedge reset) begin
    if (reset) begin
      heart_visible <= 1'b1;
    end else if (inv_step) begin
      heart_visible <= ~fc_inc[2];
    end else if ((state != INVULN) || fe) begin
      heart_visible <= 1'b1;
    end
  end
`else
  assign heart_visible = 1'b1;
`endif

endmodule

// File: tb/tb_bullet_hit_detector.sv
module tb_bullet_hit_detector;

  localparam int NB  = 2;
  localparam int HPI = 20;
  localparam int DMG = 1;
  localparam int INV = 30;

  logic          Pclk = 1'b0;
  logic          reset = 1'b0;
  logic [9:0]    xx = '0;
  logic [9:0]    yy = '0;
  logic          aactive = 1'b0;
  logic [NB-1:0] BulletSpriteOn = '0;
  logic          HeartSpriteOn = 1'b0;
  logic [NB-1:0] isCollision;
  logic [7:0]    hp;
  logic          hit_pulse;
  logic          invuln;
  logic          heart_visible;
  logic          game_over;

  bullet_hit_detector #(
    .NUM_BULLETS  (NB),
    .HP_INIT      (HPI),
    .DAMAGE       (DMG),
    .INVULN_FRAMES(INV),
    .H_LAST       (639),
    .V_LAST       (479)
  ) dut (
    .Pclk          (Pclk),
    .reset         (reset),
    .xx            (xx),
    .yy            (yy),
    .aactive       (aactive),
    .BulletSpriteOn(BulletSpriteOn),
    .HeartSpriteOn (HeartSpriteOn),
    .isCollision   (isCollision),
    .hp            (hp),
    .hit_pulse     (hit_pulse),
    .invuln        (invuln),
    .heart_visible (heart_visible),
    .game_over     (game_over)
  );

  always #20 Pclk = ~Pclk;

  int vectors = 0;
  int miscompares = 0;

  // Frame-level reference: hits gathered over a frame, a countdown of
  // remaining invulnerable frames, and a dead flag.
  int          m_hp;
  bit          m_dead;
  int          m_inv_left;
  int          m_elapsed;
  bit [NB-1:0] m_acc;
  bit [NB-1:0] m_isc;
  bit          m_pulse;

  function automatic bit exp_hv();
`ifdef HIT_FLASH_EN
    if (m_inv_left > 0) return ((m_elapsed / 4) % 2) == 0;
`endif
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_hp = HPI; m_dead = 0; m_inv_left = 0; m_elapsed = 0;
    m_acc = '0; m_isc = '0; m_pulse = 0;
  endtask

  task automatic model_step(input int x, input int y, input bit a,
                            input bit [NB-1:0] b, input bit h);
    bit          frame_end;
    bit [NB-1:0] hits;
    frame_end = (x == 639) && (y == 479);
    hits      = (a && h) ? b : '0;
    m_pulse   = 0;
    if (m_dead) begin
      // absorbing
    end else if (m_inv_left > 0) begin
      if (frame_end) begin
        m_inv_left--;
        m_elapsed++;
        if (m_inv_left == 0) begin
          m_isc = '0;
          m_elapsed = 0;
        end
      end
    end else begin
      m_acc |= hits;
      if (frame_end) begin
        if (m_acc != 0) begin
          m_hp    = (m_hp > DMG) ? m_hp - DMG : 0;
          m_pulse = 1;
          if (m_hp == 0) begin
            m_dead = 1;
            m_isc  = '1;
          end else begin
            m_isc      = m_acc;
            m_inv_left = INV;
            m_elapsed  = 0;
          end
        end
        m_acc = '0;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    bit exp_inv;
    exp_inv = (m_inv_left > 0);
    vectors++;
    if ({isCollision, hp, hit_pulse, invuln, heart_visible, game_over} !==
        {m_isc, 8'(m_hp), m_pulse, exp_inv, exp_hv(), m_dead}) begin
      miscompares++;
      $display("FAIL %s @%0t: got isc=%b hp=%0d pulse=%b inv=%b hv=%b go=%b, expected isc=%b hp=%0d pulse=%b inv=%b hv=%b go=%b",
               tag, $time, isCollision, hp, hit_pulse, invuln, heart_visible, game_over,
               m_isc, m_hp, m_pulse, exp_inv, exp_hv(), m_dead);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic apply(input int x, input int y, input bit a,
                       input bit [NB-1:0] b, input bit h, input string tag);
    xx = 10'(x); yy = 10'(y); aactive = a; BulletSpriteOn = b; HeartSpriteOn = h;
    @(posedge Pclk);
    model_step(x, y, a, b, h);
    #1;
    compare_model(tag);
  endtask

  // Compressed frame: one pixel carrying the sprites, then the frame-end pixel.
  task automatic frame(input bit [NB-1:0] b, input bit h, input bit a);
    apply(230, 220, a, b, h, "frame_ovl");
    apply(639, 479, 1'b1, '0, 1'b0, "frame_fe");
  endtask

  // Reset asserted and checked between clock edges, so it must act asynchronously.
  task automatic do_reset();
    reset = 1'b1;
    xx = '0; yy = '0; aactive = 1'b0; BulletSpriteOn = '0; HeartSpriteOn = 1'b0;
    #5;
    model_reset();
    compare_model("reset");
    chk("reset_hp", hp, HPI);
    chk("reset_invuln", invuln, 0);
    chk("reset_isc", isCollision, 0);
    chk("reset_hv", heart_visible, 1);
    #5;
    reset = 1'b0;
  endtask

  typedef struct {
    int          x, y;
    bit          a;
    bit [NB-1:0] b;
    bit          h;
    int          e_hp;
    bit          e_pulse;
    bit [NB-1:0] e_isc;
    bit          e_inv;
    bit          e_go;
  } vec_t;

  vec_t tbl[8];
  bit   flash_pat[8];

  initial begin
    tbl[0] = '{230, 220, 0, 2'b01, 1, 20, 0, 2'b00, 0, 0}; // aactive low: ignored
    tbl[1] = '{639, 479, 1, 2'b00, 0, 20, 0, 2'b00, 0, 0}; // fe, no hit
    tbl[2] = '{230, 220, 1, 2'b01, 1, 20, 0, 2'b00, 0, 0}; // overlap latched
    tbl[3] = '{100, 300, 1, 2'b00, 1, 20, 0, 2'b00, 0, 0};
    tbl[4] = '{639, 479, 1, 2'b00, 0, 19, 1, 2'b01, 1, 0}; // commit
    tbl[5] = '{  0,   0, 1, 2'b00, 0, 19, 0, 2'b01, 1, 0}; // pulse gone
    tbl[6] = '{230, 220, 1, 2'b11, 1, 19, 0, 2'b01, 1, 0}; // ignored in invuln
    tbl[7] = '{639, 479, 1, 2'b00, 0, 19, 0, 2'b01, 1, 0};
    flash_pat = '{1, 1, 1, 1, 0, 0, 0, 0};

    // Table-driven opening sequence
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].x, tbl[i].y, tbl[i].a, tbl[i].b, tbl[i].h, "table");
      vectors++;
      if ({hp, hit_pulse, isCollision, invuln, game_over} !==
          {8'(tbl[i].e_hp), tbl[i].e_pulse, tbl[i].e_isc, tbl[i].e_inv, tbl[i].e_go}) begin
        miscompares++;
        $display("FAIL table[%0d]: got hp=%0d pulse=%b isc=%b inv=%b go=%b, expected hp=%0d pulse=%b isc=%b inv=%b go=%b",
                 i, hp, hit_pulse, isCollision, invuln, game_over,
                 tbl[i].e_hp, tbl[i].e_pulse, tbl[i].e_isc, tbl[i].e_inv, tbl[i].e_go);
      end
    end

    // Invulnerability window with continuous overlaps
    do_reset();
    frame(2'b01, 1, 1);
    chk("win_hit_hp", hp, 19);
    for (int k = 0; k < INV - 1; k++) frame(2'b11, 1, 1);
    chk("win_still_inv", invuln, 1);
    chk("win_hp_held", hp, 19);
    chk("win_isc_held", isCollision, 1);
    frame(2'b11, 1, 1);
    chk("win_exit_inv", invuln, 0);
    chk("win_exit_isc", isCollision, 0);
    frame(2'b10, 1, 1);
    chk("win_rehit_hp", hp, 18);
    chk("win_rehit_isc", isCollision, 2);

    // Dual overlap costs one damage
    do_reset();
    frame(2'b11, 1, 1);
    chk("dual_hp", hp, 19);
    chk("dual_isc", isCollision, 3);

    // Overlap only on the frame-end pixel
    do_reset();
    apply(639, 479, 1, 2'b01, 1, "fe_only");
    chk("fe_only_hp", hp, 19);
    chk("fe_only_pulse", hit_pulse, 1);
    do_reset();
    apply(639, 479, 0, 2'b01, 1, "fe_only_inactive");
    chk("fe_inactive_hp", hp, 20);
    chk("fe_inactive_pulse", hit_pulse, 0);

    // Death and absorbing DEAD state
    do_reset();
    for (int n = 0; n < HPI; n++) begin
      frame(2'b01, 1, 1);
      if (n != HPI - 1) for (int k = 0; k < INV; k++) frame(2'b00, 0, 1);
    end
    chk("dead_hp", hp, 0);
    chk("dead_go", game_over, 1);
    chk("dead_isc", isCollision, 3);
    for (int k = 0; k < 3; k++) begin
      frame(2'b11, 1, 1);
      chk("dead_no_pulse", hit_pulse, 0);
    end

    // Async reset in the middle of the window; flash pattern across frames
    do_reset();
    frame(2'b01, 1, 1);
    for (int k = 0; k < 12; k++) begin
`ifdef HIT_FLASH_EN
      if (k < 8) chk("flash_pattern", heart_visible, flash_pat[k]);
`endif
      frame(2'b00, 0, 1);
    end
    chk("mid_inv_before", invuln, 1);
    do_reset();
    apply(0, 0, 0, 2'b00, 0, "post_reset");

    // Randomized stimulus against the reference model
    for (int c = 0; c < 9000; c++) begin
      int r, x, y;
      if (c == 4500) do_reset();
      r = $urandom_range(0, 9);
      if (r == 0) begin
        x = 639; y = 479;
      end else if (r == 1) begin
        x = 639; y = $urandom_range(0, 478);
      end else begin
        x = $urandom_range(0, 638); y = $urandom_range(0, 479);
      end
      apply(x, y, $urandom_range(0, 3) != 0, NB'($urandom), 1'($urandom_range(0, 1)), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
